// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending machine controller
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_e;

    localparam logic [1:0] SEL_NONE  = 2'd0;
    localparam logic [1:0] SEL_EXPR  = 2'd1;
    localparam logic [1:0] SEL_LATTE = 2'd2;
    localparam logic [1:0] SEL_CAPP  = 2'd3;

    localparam int COIN5  = 5;
    localparam int COIN10 = 10;

endpackage

// File: rtl/vend_dispense_timer.sv
// rtl/vend_dispense_timer.sv - loadable down-counter timing the dispense output
module vend_dispense_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q;

    // Load the full duration on entry; count down to zero and then rest there
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= W'(CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Asserted during the final dispense cycle
    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/vend_fsm.sv
// rtl/vend_fsm.sv - multi-product vending FSM; VEND_SALES_COUNT_EN adds per-product sales counters
module vend_fsm
    import vend_pkg::*;
#(
    parameter int CREDIT_W        = 8,
    parameter int PRICE_EXPR      = 5,
    parameter int PRICE_LATTE     = 10,
    parameter int PRICE_CAPP      = 15,
    parameter int MAX_CREDIT      = 30,
    parameter int DISPENSE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                credit5,
    input  logic                credit10,
    input  logic [1:0]          coffee_type,
    input  logic                cancel,
    output logic                expr,
    output logic                latte,
    output logic                capp,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_reject,
    output logic                insufficient,
`ifdef VEND_SALES_COUNT_EN
    output logic [15:0]         sales_expr,
    output logic [15:0]         sales_latte,
    output logic [15:0]         sales_capp,
`endif
    output logic                busy
);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [2:0]          prod_q, prod_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
    logic                coin_reject_q, coin_reject_d;
    logic                insufficient_q, insufficient_d;
    logic                busy_q, busy_d;
    logic                timer_load;
    logic                timer_done;

    logic                coin_any;
    logic [CREDIT_W:0]   deposit;
    logic [CREDIT_W:0]   credit_sum;
    logic [CREDIT_W:0]   price_sel;
    logic [2:0]          prod_sel;

    vend_dispense_timer #(
        .CYCLES(DISPENSE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .done (timer_done)
    );

    // Decode the deposit and the selected product's price and one-hot output
    always_comb begin
        coin_any = credit5 | credit10;
        deposit  = '0;
        if (credit5) begin
            deposit = deposit + (CREDIT_W+1)'(COIN5);
        end
        if (credit10) begin
            deposit = deposit + (CREDIT_W+1)'(COIN10);
        end
        credit_sum = {1'b0, credit_q} + deposit;
        price_sel  = '0;
        prod_sel   = 3'b000;
        case (coffee_type)
            SEL_EXPR: begin
                price_sel = (CREDIT_W+1)'(PRICE_EXPR);
                prod_sel  = 3'b001;
            end
            SEL_LATTE: begin
                price_sel = (CREDIT_W+1)'(PRICE_LATTE);
                prod_sel  = 3'b010;
            end
            SEL_CAPP: begin
                price_sel = (CREDIT_W+1)'(PRICE_CAPP);
                prod_sel  = 3'b100;
            end
            default: begin
                price_sel = '0;
                prod_sel  = 3'b000;
            end
        endcase
    end

    // Next state and next registered outputs; priority cancel > selection > coin
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        prod_d         = prod_q;
        change_valid_d = 1'b0;
        change_amt_d   = change_amt_q;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;
        busy_d         = 1'b0;
        timer_load     = 1'b0;
        case (state_q)
            IDLE, CREDIT: begin
                if (cancel && state_q == CREDIT) begin
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                    credit_d       = '0;
                    busy_d         = 1'b1;
                    coin_reject_d  = coin_any;
                end else if (coffee_type != SEL_NONE) begin
                    coin_reject_d = coin_any;
                    if ({1'b0, credit_q} >= price_sel) begin
                        credit_d   = credit_q - price_sel[CREDIT_W-1:0];
                        prod_d     = prod_sel;
                        timer_load = 1'b1;
                        state_d    = DISPENSE;
                        busy_d     = 1'b1;
                    end else begin
                        insufficient_d = 1'b1;
                    end
                end else if (coin_any) begin
                    if (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = coin_any;
                busy_d        = 1'b1;
                if (timer_done) begin
                    prod_d = 3'b000;
                    if (credit_q != '0) begin
                        state_d        = CHANGE;
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                        credit_d       = '0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                coin_reject_d = coin_any;
                state_d       = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops everything, including held credit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            prod_q         <= 3'b000;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            prod_q         <= prod_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
            busy_q         <= busy_d;
        end
    end

`ifdef VEND_SALES_COUNT_EN
    logic [15:0] sales_expr_q, sales_latte_q, sales_capp_q;

    // Count each sale as it enters DISPENSE, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            sales_expr_q  <= '0;
            sales_latte_q <= '0;
            sales_capp_q  <= '0;
        end else if (timer_load) begin
            if (prod_d[0] && sales_expr_q != 16'hFFFF) begin
                sales_expr_q <= sales_expr_q + 16'd1;
            end
            if (prod_d[1] && sales_latte_q != 16'hFFFF) begin
                sales_latte_q <= sales_latte_q + 16'd1;
            end
            if (prod_d[2] && sales_capp_q != 16'hFFFF) begin
                sales_capp_q <= sales_capp_q + 16'd1;
            end
        end
    end

    assign sales_expr  = sales_expr_q;
    assign sales_latte = sales_latte_q;
    assign sales_capp  = sales_capp_q;
`endif

    assign expr         = prod_q[0];
    assign latte        = prod_q[1];
    assign capp         = prod_q[2];
    assign credit       = credit_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign insufficient = insufficient_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_fsm.sv
// tb/tb_vend_fsm.sv - directed self-checking bench for vend_fsm at default parameters
module tb_vend_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       credit5;
    logic       credit10;
    logic [1:0] coffee_type;
    logic       cancel;
    logic       expr;
    logic       latte;
    logic       capp;
    logic [7:0] credit;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       coin_reject;
    logic       insufficient;
    logic       busy;
`ifdef VEND_SALES_COUNT_EN
    logic [15:0] sales_expr;
    logic [15:0] sales_latte;
    logic [15:0] sales_capp;
`endif

    int checks   = 0;
    int failures = 0;

    vend_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .credit5      (credit5),
        .credit10     (credit10),
        .coffee_type  (coffee_type),
        .cancel       (cancel),
        .expr         (expr),
        .latte        (latte),
        .capp         (capp),
        .credit       (credit),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .coin_reject  (coin_reject),
        .insufficient (insufficient),
`ifdef VEND_SALES_COUNT_EN
        .sales_expr   (sales_expr),
        .sales_latte  (sales_latte),
        .sales_capp   (sales_capp),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        credit5     = 1'b0;
        credit10    = 1'b0;
        coffee_type = 2'd0;
        cancel      = 1'b0;
    endtask

    // Counts consecutive cycles a product output is high; the caller has already seen the first
    task automatic count_dispense(output int n, output logic cv_at_end, output logic busy_at_end);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (expr | latte | capp) n++;
            else break;
        end
        cv_at_end   = change_valid;
        busy_at_end = busy;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({expr, latte, capp, change_valid, coin_reject, insufficient, busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_pulses got=%b exp=0000000", {expr, latte, capp, change_valid, coin_reject, insufficient, busy});
        end
        checks++;
        if (credit !== 8'd0 || change_amt !== 8'd0) begin
            failures++;
            $display("FAIL reset_credit got credit=%0d change_amt=%0d exp=0 0", credit, change_amt);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_exact_price();
        int n;
        logic cv, bz;
        credit5 = 1'b1;
        cyc();
        idle_inputs();
        checks++;
        if (credit !== 8'd5) begin
            failures++;
            $display("FAIL exact_credit got=%0d exp=5", credit);
        end
        coffee_type = 2'd1;
        cyc();
        idle_inputs();
        checks++;
        if (expr !== 1'b1 || credit !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL exact_start got expr=%b credit=%0d busy=%b exp 1 0 1", expr, credit, busy);
        end
        count_dispense(n, cv, bz);
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL exact_len got=%0d exp=4", n);
        end
        checks++;
        if (cv !== 1'b0 || bz !== 1'b0) begin
            failures++;
            $display("FAIL exact_end got change_valid=%b busy=%b exp 0 0", cv, bz);
        end
    endtask

    task automatic test_change();
        int n;
        logic cv, bz;
        credit10 = 1'b1;
        cyc();
        cyc();
        idle_inputs();
        checks++;
        if (credit !== 8'd20) begin
            failures++;
            $display("FAIL change_credit got=%0d exp=20", credit);
        end
        coffee_type = 2'd3;
        cyc();
        idle_inputs();
        checks++;
        if (capp !== 1'b1 || expr !== 1'b0 || latte !== 1'b0 || credit !== 8'd5) begin
            failures++;
            $display("FAIL change_start got capp=%b expr=%b latte=%b credit=%0d exp 1 0 0 5", capp, expr, latte, credit);
        end
        count_dispense(n, cv, bz);
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL change_len got=%0d exp=4", n);
        end
        checks++;
        if (cv !== 1'b1 || change_amt !== 8'd5 || credit !== 8'd0 || bz !== 1'b1) begin
            failures++;
            $display("FAIL change_pay got valid=%b amt=%0d credit=%0d busy=%b exp 1 5 0 1", cv, change_amt, credit, bz);
        end
        cyc();
        checks++;
        if (change_valid !== 1'b0 || change_amt !== 8'd5 || busy !== 1'b0) begin
            failures++;
            $display("FAIL change_after got valid=%b amt=%0d busy=%b exp 0 5 0", change_valid, change_amt, busy);
        end
    endtask

    task automatic test_insufficient();
        int n;
        logic cv, bz;
        credit5 = 1'b1;
        cyc();
        idle_inputs();
        coffee_type = 2'd2;
        cyc();
        idle_inputs();
        checks++;
        if (insufficient !== 1'b1 || credit !== 8'd5 || latte !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL insuf_pulse got insuf=%b credit=%0d latte=%b busy=%b exp 1 5 0 0", insufficient, credit, latte, busy);
        end
        cyc();
        checks++;
        if (insufficient !== 1'b0) begin
            failures++;
            $display("FAIL insuf_oneshot got=%b exp=0", insufficient);
        end
        credit5 = 1'b1;
        cyc();
        idle_inputs();
        coffee_type = 2'd2;
        cyc();
        idle_inputs();
        checks++;
        if (latte !== 1'b1 || credit !== 8'd0) begin
            failures++;
            $display("FAIL insuf_sale got latte=%b credit=%0d exp 1 0", latte, credit);
        end
        count_dispense(n, cv, bz);
        checks++;
        if (n !== 4 || cv !== 1'b0) begin
            failures++;
            $display("FAIL insuf_end got len=%0d change_valid=%b exp 4 0", n, cv);
        end
    endtask

    task automatic test_overflow();
        credit5  = 1'b1;
        credit10 = 1'b1;
        cyc();
        idle_inputs();
        checks++;
        if (credit !== 8'd15 || coin_reject !== 1'b0) begin
            failures++;
            $display("FAIL ovf_both got credit=%0d reject=%b exp 15 0", credit, coin_reject);
        end
        credit10 = 1'b1;
        cyc();
        checks++;
        if (credit !== 8'd25) begin
            failures++;
            $display("FAIL ovf_25 got=%0d exp=25", credit);
        end
        cyc();
        idle_inputs();
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd25) begin
            failures++;
            $display("FAIL ovf_reject got reject=%b credit=%0d exp 1 25", coin_reject, credit);
        end
        credit5 = 1'b1;
        cyc();
        idle_inputs();
        checks++;
        if (coin_reject !== 1'b0 || credit !== 8'd30) begin
            failures++;
            $display("FAIL ovf_max got reject=%b credit=%0d exp 0 30", coin_reject, credit);
        end
        cancel = 1'b1;
        cyc();
        idle_inputs();
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 8'd30 || credit !== 8'd0) begin
            failures++;
            $display("FAIL ovf_refund got valid=%b amt=%0d credit=%0d exp 1 30 0", change_valid, change_amt, credit);
        end
        cyc();
    endtask

    task automatic test_cancel_priority();
        credit10 = 1'b1;
        cyc();
        idle_inputs();
        cancel = 1'b1;
        cyc();
        idle_inputs();
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 8'd10 || credit !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cancel_pay got valid=%b amt=%0d credit=%0d busy=%b exp 1 10 0 1", change_valid, change_amt, credit, busy);
        end
        cyc();
        checks++;
        if (change_valid !== 1'b0 || change_amt !== 8'd10 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cancel_hold got valid=%b amt=%0d busy=%b exp 0 10 0", change_valid, change_amt, busy);
        end
        credit5     = 1'b1;
        coffee_type = 2'd1;
        cyc();
        idle_inputs();
        checks++;
        if (insufficient !== 1'b1 || coin_reject !== 1'b1 || credit !== 8'd0 || expr !== 1'b0) begin
            failures++;
            $display("FAIL prio_sel_coin got insuf=%b reject=%b credit=%0d expr=%b exp 1 1 0 0", insufficient, coin_reject, credit, expr);
        end
        cyc();
    endtask

    task automatic test_reset_mid_dispense();
        credit10 = 1'b1;
        cyc();
        cyc();
        idle_inputs();
        coffee_type = 2'd1;
        cyc();
        idle_inputs();
        checks++;
        if (expr !== 1'b1 || credit !== 8'd15) begin
            failures++;
            $display("FAIL mid_start got expr=%b credit=%0d exp 1 15", expr, credit);
        end
        credit5     = 1'b1;
        coffee_type = 2'd2;
        cyc();
        idle_inputs();
        checks++;
        if (coin_reject !== 1'b1 || insufficient !== 1'b0 || credit !== 8'd15 || expr !== 1'b1 || latte !== 1'b0) begin
            failures++;
            $display("FAIL mid_ignore got reject=%b insuf=%b credit=%0d expr=%b latte=%b exp 1 0 15 1 0", coin_reject, insufficient, credit, expr, latte);
        end
`ifdef VEND_SALES_COUNT_EN
        checks++;
        if (sales_expr !== 16'd2 || sales_latte !== 16'd1 || sales_capp !== 16'd1) begin
            failures++;
            $display("FAIL sales_count got %0d %0d %0d exp 2 1 1", sales_expr, sales_latte, sales_capp);
        end
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (expr !== 1'b0 || credit !== 8'd0 || change_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got expr=%b credit=%0d valid=%b busy=%b exp 0 0 0 0", expr, credit, change_valid, busy);
        end
`ifdef VEND_SALES_COUNT_EN
        checks++;
        if (sales_expr !== 16'd0) begin
            failures++;
            $display("FAIL sales_reset got=%0d exp=0", sales_expr);
        end
`endif
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (change_valid !== 1'b0 || expr !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_change cycle=%0d got valid=%b expr=%b exp 0 0", i, change_valid, expr);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_exact_price();
        test_change();
        test_insufficient();
        test_overflow();
        test_cancel_priority();
        test_reset_mid_dispense();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_fsm.md
Name: vend_fsm

Overview:
- Parametrised successor to the single-price coffee FSM.
- Accumulates coin credit, sells one of three products at independently parametrised prices, holds the dispense output for a programmable time, then returns change.
- Supports cancel/refund, coin rejection on overflow, and an "insufficient credit" indication.
- Sits between the coin-acceptor/keypad debouncers and the dispenser actuator drivers.

Parameters:
- CREDIT_W, 8, width of the credit and change registers (bits).
- PRICE_EXPR, 5, price of expresso in credit units.
- PRICE_LATTE, 10, price of latte.
- PRICE_CAPP, 15, price of cappuccino.
- MAX_CREDIT, 30, maximum credit held; must be < 2**CREDIT_W.
- DISPENSE_CYCLES, 4, clock cycles the product output stays high; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- credit5  in  1  5-unit coin, one-cycle pulse.
- credit10  in  1  10-unit coin, one-cycle pulse.
- coffee_type  in  2  selection: 0 none, 1 expresso, 2 latte, 3 cappuccino; sampled each cycle.
- cancel  in  1  refund request, one-cycle pulse.
- expr  out  1  expresso dispense, high for DISPENSE_CYCLES.
- latte  out  1  latte dispense.
- capp  out  1  cappuccino dispense.
- credit  out  CREDIT_W  current credit, registered.
- change_valid  out  1  one-cycle pulse; change_amt is valid.
- change_amt  out  CREDIT_W  amount returned.
- coin_reject  out  1  one-cycle pulse; the coin was not accepted.
- insufficient  out  1  one-cycle pulse; the selection was refused.
- busy  out  1  high in DISPENSE and CHANGE.

Behaviour:
- Reset: state IDLE. All outputs are 0, including credit, change_amt, and every pulse output.
- Outputs are registered. Every response appears on the cycle after the triggering input.
- States:
  - IDLE: no credit.
  - CREDIT: credit > 0.
  - DISPENSE: product output held.
  - CHANGE: one cycle, emits change.
- Coin value: credit5 adds 5, credit10 adds 10. Both in the same cycle add 15 as a single deposit.
- Coin acceptance (IDLE or CREDIT):
  - If credit + value ≤ MAX_CREDIT, credit updates and the state becomes CREDIT.
  - Otherwise the whole deposit is rejected, coin_reject = 1, and credit is unchanged.
- Selection (coffee_type ≠ 0, in IDLE or CREDIT):
  - If credit ≥ price: credit -= price, raise the matching one-hot output, load the dispense counter, go to DISPENSE.
  - Otherwise: insufficient = 1, stay in the current state.
- Priority in a single cycle: rst > cancel > selection > coin.
  - A coin arriving in the same cycle as an accepted or refused selection, or as a cancel, is rejected (coin_reject = 1).
- Cancel:
  - In CREDIT: go to CHANGE.
  - In IDLE, DISPENSE, or CHANGE: ignored.
- DISPENSE:
  - Exactly one of expr/latte/capp is high for exactly DISPENSE_CYCLES cycles.
  - Coins are rejected and selections are ignored (no insufficient pulse).
  - After the last cycle: go to CHANGE if credit > 0, else IDLE.
- CHANGE:
  - change_valid = 1 and change_amt = credit for one cycle; credit becomes 0 in the same cycle.
  - Next state is IDLE.
  - Coins are rejected.
- change_amt holds its last value while change_valid = 0.
- Arithmetic: unsigned, CREDIT_W bits. No wrap is possible given the MAX_CREDIT check.
- Reset asserted mid-dispense: outputs drop on the next edge, and the credit is lost (no change is paid).

Optional Feature:
- Macro: VEND_SALES_COUNT_EN.
- When defined:
  - Adds outputs sales_expr, sales_latte, sales_capp, each 16 bits.
  - Each counter increments on entry to DISPENSE for its product.
  - Counters saturate at 16'hFFFF and clear on rst.
- When undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package vend_pkg:
  - State encoding: IDLE, CREDIT, DISPENSE, CHANGE.
  - Product codes: SEL_NONE = 0, SEL_EXPR = 1, SEL_LATTE = 2, SEL_CAPP = 3.
  - Coin values COIN5 = 5, COIN10 = 10.
- One sub-module, vend_dispense_timer:
  - Loadable down-counter, $clog2(DISPENSE_CYCLES+1) bits.
  - Ports: load, done.
  - Owned by vend_fsm.

Test Plan:
- Exact-price sale, defaults: credit5 → credit = 5; select 1 → expr high 4 cycles, credit = 0, no change_valid, return to IDLE.
- Overpay with change: credit10, credit10 (credit = 20); select 3 → capp high 4 cycles, then change_valid with change_amt = 5, credit = 0.
- Insufficient credit: credit5; select 2 → insufficient pulse, credit stays 5, latte stays 0. Then credit5 and select 2 → latte dispensed, no change.
- Overflow and simultaneous coins: credit5 + credit10 in the same cycle → credit = 15. credit10 → 25. credit10 → coin_reject, credit = 25. credit5 → 30.
- Cancel, and priority in a single cycle: credit10, then cancel → change_amt = 10, IDLE. Next, credit5 together with select 1 → insufficient and coin_reject pulses, credit stays 0.
- Reset mid-dispense: credit = 20, select 1; rst on the 2nd dispense cycle → expr = 0, credit = 0, no change_valid. With VEND_SALES_COUNT_EN defined, sales_expr = 0 after reset.
